// File: rtl/mem_dbus_if.sv
// Wishbone-classic data-bus bundle between the MEM-stage master and a data slave.
// The _o/_i suffixes are from the master's point of view.
interface mem_dbus_if;
    logic [31:0] dbus_adr_o;
    logic [31:0] dbus_dat_o;
    logic [31:0] dbus_dat_i;
    logic        dbus_we_o;
    logic [3:0]  dbus_sel_o;
    logic        dbus_stb_o;
    logic        dbus_cyc_o;
    logic        dbus_ack_i;

    modport master (
        output dbus_adr_o, dbus_dat_o, dbus_we_o, dbus_sel_o, dbus_stb_o, dbus_cyc_o,
        input  dbus_dat_i, dbus_ack_i
    );

    modport slave (
        input  dbus_adr_o, dbus_dat_o, dbus_we_o, dbus_sel_o, dbus_stb_o, dbus_cyc_o,
        output dbus_dat_i, dbus_ack_i
    );
endinterface

// File: rtl/mem_dbus_master.sv
// MEM-stage memory-access unit: turns load/store ops into single Wishbone-classic cycles,
// forms big-endian byte lanes, extends load data and stalls the pipeline until done.
module mem_dbus_master #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  i_stall,
    input  logic        i_flush,
    input  logic [7:0]  i_mem_aluop,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_reg2,
    input  logic [4:0]  i_mem_wd,
    input  logic        i_mem_wreg,
    input  logic [31:0] i_mem_wdata,
    output logic [4:0]  o_wb_wd,
    output logic        o_wb_wreg,
    output logic [31:0] o_wb_wdata,
    output logic        o_stallreq,
    output logic        o_align_err,
    output logic        o_bus_err,
    mem_dbus_if.master  dbus
);

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    localparam logic [CNT_W-1:0] LAST_CNT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;
    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_t;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_adr, w_adr_nxt;
    logic [31:0]      r_dat, w_dat_nxt;
    logic [3:0]       r_sel, w_sel_nxt;
    logic             r_we, w_we_nxt;
    logic             r_cyc, w_cyc_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]       r_op, w_op_nxt;
    logic [31:0]      r_result, w_result_nxt;
    logic             r_bus_err, w_bus_err_nxt;

    logic        w_is_load;
    logic        w_is_store;
    size_t       w_size;
    logic        w_misalign;
    logic        w_go;
    logic [3:0]  w_sel;
    logic [31:0] w_wdat;
    logic [31:0] w_load_ext;
    logic        w_unused;

    // Only stall[4] (MEM stage) matters here.
    assign w_unused = ^{i_stall[5], i_stall[3:0]};

    function automatic logic [31:0] f_extend(logic [7:0] op, logic [1:0] a, logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = d[31:24];
            2'd1:    b = d[23:16];
            2'd2:    b = d[15:8];
            default: b = d[7:0];
        endcase
        h = a[1] ? d[15:0] : d[31:16];
        case (op)
            OP_LB:   f_extend = {{24{b[7]}}, b};
            OP_LBU:  f_extend = {24'h0, b};
            OP_LH:   f_extend = {{16{h[15]}}, h};
            OP_LHU:  f_extend = {16'h0, h};
            OP_LW:   f_extend = d;
            default: f_extend = 32'h0;
        endcase
    endfunction

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size     = SzWord;
        case (i_mem_aluop)
            OP_LB, OP_LBU: begin w_is_load  = 1'b1; w_size = SzByte; end
            OP_LH, OP_LHU: begin w_is_load  = 1'b1; w_size = SzHalf; end
            OP_LW:         begin w_is_load  = 1'b1; w_size = SzWord; end
            OP_SB:         begin w_is_store = 1'b1; w_size = SzByte; end
            OP_SH:         begin w_is_store = 1'b1; w_size = SzHalf; end
            OP_SW:         begin w_is_store = 1'b1; w_size = SzWord; end
            default:       ;
        endcase
    end

    assign w_misalign = (w_is_load || w_is_store) &&
                        (((w_size == SzHalf) && i_mem_addr[0]) ||
                         ((w_size == SzWord) && (i_mem_addr[1:0] != 2'b00)));
    assign w_go       = (w_is_load || w_is_store) && !w_misalign && !i_flush;

    // Big-endian lanes: lowest address maps to the most significant byte.
    always_comb begin
        w_sel  = 4'b1111;
        w_wdat = i_mem_reg2;
        case (w_size)
            SzByte: begin
                w_sel  = 4'b1000 >> i_mem_addr[1:0];
                w_wdat = {4{i_mem_reg2[7:0]}};
            end
            SzHalf: begin
                w_sel  = i_mem_addr[1] ? 4'b0011 : 4'b1100;
                w_wdat = {2{i_mem_reg2[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_load_ext = f_extend(r_op, r_adr[1:0], dbus.dbus_dat_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_we      <= 1'b0;
            r_cyc     <= 1'b0;
            r_cnt     <= '0;
            r_op      <= '0;
            r_result  <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_adr     <= w_adr_nxt;
            r_dat     <= w_dat_nxt;
            r_sel     <= w_sel_nxt;
            r_we      <= w_we_nxt;
            r_cyc     <= w_cyc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_op      <= w_op_nxt;
            r_result  <= w_result_nxt;
            r_bus_err <= w_bus_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_adr_nxt     = r_adr;
        w_dat_nxt     = r_dat;
        w_sel_nxt     = r_sel;
        w_we_nxt      = r_we;
        w_cyc_nxt     = r_cyc;
        w_cnt_nxt     = r_cnt;
        w_op_nxt      = r_op;
        w_result_nxt  = r_result;
        w_bus_err_nxt = 1'b0;
        if (i_flush) begin
            w_state_nxt  = StIdle;
            w_cyc_nxt    = 1'b0;
            w_we_nxt     = 1'b0;
            w_sel_nxt    = 4'b0000;
            w_result_nxt = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_go) begin
                        w_adr_nxt   = i_mem_addr;
                        w_dat_nxt   = w_wdat;
                        w_sel_nxt   = w_sel;
                        w_we_nxt    = w_is_store;
                        w_cyc_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_op_nxt    = i_mem_aluop;
                        w_state_nxt = StBusy;
                    end
                end
                StBusy: begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (dbus.dbus_ack_i) begin
                        w_result_nxt = w_load_ext;
                        w_cyc_nxt    = 1'b0;
                        w_we_nxt     = 1'b0;
                        w_sel_nxt    = 4'b0000;
                        w_state_nxt  = StDone;
                    end else if ((TIMEOUT != 0) && (r_cnt == LAST_CNT)) begin
                        w_result_nxt  = '0;
                        w_bus_err_nxt = 1'b1;
                        w_cyc_nxt     = 1'b0;
                        w_we_nxt      = 1'b0;
                        w_sel_nxt     = 4'b0000;
                        w_state_nxt   = StDone;
                    end
                end
                // Holding here under stall[4] keeps the op from re-issuing.
                StDone: begin
                    if (!i_stall[4]) w_state_nxt = StIdle;
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_comb begin
        o_stallreq = 1'b0;
        case (r_state)
            StIdle:  o_stallreq = w_go;
            StBusy:  o_stallreq = 1'b1;
            default: o_stallreq = 1'b0;
        endcase
    end

    assign o_align_err = w_misalign;
    assign o_bus_err   = r_bus_err;
    assign o_wb_wd     = i_mem_wd;
    assign o_wb_wreg   = i_mem_wreg && !w_misalign;
    assign o_wb_wdata  = ((r_state == StDone) && w_is_load) ? r_result : i_mem_wdata;

    assign dbus.dbus_adr_o = r_adr;
    assign dbus.dbus_dat_o = r_dat;
    assign dbus.dbus_sel_o = r_sel;
    assign dbus.dbus_we_o  = r_we;
    assign dbus.dbus_cyc_o = r_cyc;
    assign dbus.dbus_stb_o = r_cyc;

endmodule
